coef_rom_arbiter: RTL and testbench

- Shares the single polynomial-coefficient ROM (7-bit address, Coef2/Coef1 18 b, Coef0 21 b) between two evaluation requesters in the Gaussian noise generator: requester 0 is the ln/sqrt path and requester 1 is the sin/cos path.
- Round-robin arbitration, one lookup in flight at a time.
- Drives the ROM read_en/address, waits a parameterised ROM latency, captures the coefficient triple and returns it with a per-requester valid pulse.

---
 rtl/coef_rom_arbiter_pkg.sv | 27 ++
 rtl/coef_rom_arbiter_if.sv | 50 +++++
 rtl/coef_rom_arbiter_rr_arb2.sv | 30 +++
 rtl/coef_rom_arbiter.sv | 141 ++++++++++++++
 tb/tb_coef_rom_arbiter.sv | 394 +++++++++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/coef_rom_arbiter_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : coef_pkg
//  Description : Shared widths, FSM state encoding and requester IDs for the
//                polynomial-coefficient ROM arbiter.
//  Revision    : 1.0 - initial release
// ============================================================================
package coef_pkg;

  localparam int unsigned ADDR_W = 7;
  localparam int unsigned C2_W   = 18;
  localparam int unsigned C1_W   = 18;
  localparam int unsigned C0_W   = 21;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_READ = 2'd1,
    ST_WAIT = 2'd2,
    ST_DONE = 2'd3
  } state_e;

  // Requester 0 is the ln/sqrt path, requester 1 the sin/cos path
  localparam logic REQ_LN   = 1'b0;
  localparam logic REQ_TRIG = 1'b1;

endpackage
`default_nettype wire

// File: rtl/coef_rom_arbiter_if.sv
`default_nettype none
// ============================================================================
//  Module      : coef_rom_arbiter_if
//  Description : Requester handshake, result bus and ROM port of the
//                coefficient ROM arbiter. The slave modport is the arbiter's
//                view; master is the view of the requesters and the ROM.
//  Revision    : 1.0 - initial release
// ============================================================================
interface coef_rom_arbiter_if #(
  parameter int unsigned ADDR_W = coef_pkg::ADDR_W,
  parameter int unsigned C2_W   = coef_pkg::C2_W,
  parameter int unsigned C1_W   = coef_pkg::C1_W,
  parameter int unsigned C0_W   = coef_pkg::C0_W
);

  // Requester side
  logic              req0;
  logic [ADDR_W-1:0] addr0;
  logic              req1;
  logic [ADDR_W-1:0] addr1;
  logic              gnt0;
  logic              gnt1;
  logic              vld0;
  logic              vld1;
  logic [C2_W-1:0]   coef2_o;
  logic [C1_W-1:0]   coef1_o;
  logic [C0_W-1:0]   coef0_o;
  logic              busy;

  // ROM side
  logic [ADDR_W-1:0] rom_address;
  logic              rom_read_en;
  logic [C2_W-1:0]   rom_coef2;
  logic [C1_W-1:0]   rom_coef1;
  logic [C0_W-1:0]   rom_coef0;

  modport slave (
    input  req0, addr0, req1, addr1, rom_coef2, rom_coef1, rom_coef0,
    output gnt0, gnt1, vld0, vld1, coef2_o, coef1_o, coef0_o, busy,
           rom_address, rom_read_en
  );

  modport master (
    output req0, addr0, req1, addr1, rom_coef2, rom_coef1, rom_coef0,
    input  gnt0, gnt1, vld0, vld1, coef2_o, coef1_o, coef0_o, busy,
           rom_address, rom_read_en
  );

endinterface
`default_nettype wire

// File: rtl/coef_rom_arbiter_rr_arb2.sv
`default_nettype none
// ============================================================================
//  Module      : rr_arb2
//  Description : Combinational two-way round-robin winner select. A lone
//                request always wins; on a tie the requester that was not
//                granted last time wins.
//  Revision    : 1.0 - initial release
// ============================================================================
module rr_arb2 (
  input  logic req0_i,
  input  logic req1_i,
  input  logic last_gnt_i,
  output logic win_o,
  output logic sel_o
);
  import coef_pkg::*;

  // Winner select: tie goes to whoever did not win last
  always_comb begin
    win_o = req0_i | req1_i;
    sel_o = REQ_LN;
    if (req0_i && req1_i) begin
      sel_o = (last_gnt_i == REQ_LN) ? REQ_TRIG : REQ_LN;
    end else if (req1_i) begin
      sel_o = REQ_TRIG;
    end
  end

endmodule
`default_nettype wire

// File: rtl/coef_rom_arbiter.sv
`default_nettype none
// ============================================================================
//  Module      : coef_rom_arbiter
//  Description : Shares the polynomial-coefficient ROM between the ln/sqrt
//                and sin/cos evaluators. Round-robin arbitration, one lookup
//                in flight, ROM_LAT-cycle ROM wait, captured coefficient
//                triple returned with a per-requester valid pulse.
//  Revision    : 1.0 - initial release
// ============================================================================
module coef_rom_arbiter #(
  parameter int unsigned ADDR_W  = coef_pkg::ADDR_W,
  parameter int unsigned C2_W    = coef_pkg::C2_W,
  parameter int unsigned C1_W    = coef_pkg::C1_W,
  parameter int unsigned C0_W    = coef_pkg::C0_W,
  parameter int unsigned ROM_LAT = 0
) (
  input  logic              clk,
  input  logic              rst_n,
  coef_rom_arbiter_if.slave bus
);
  import coef_pkg::*;

  // A combinational ROM is captured in READ itself; otherwise WAIT counts
  // ROM_LAT-1 down to 0 so that read_en spans ROM_LAT+1 cycles in total.
  localparam bit         c_comb_rom = (ROM_LAT == 0);
  localparam logic [2:0] c_lat_m1   = (ROM_LAT == 0) ? 3'd0 : 3'(ROM_LAT - 1);

  state_e            state_q, state_d;
  logic              owner_q, owner_d;
  logic              last_gnt_q, last_gnt_d;
  logic [2:0]        cnt_q, cnt_d;
  logic              busy_q;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [C2_W-1:0]   coef2_q, coef2_d;
  logic [C1_W-1:0]   coef1_q, coef1_d;
  logic [C0_W-1:0]   coef0_q, coef0_d;
  logic              w_capture;
  logic              w_win;
  logic              w_sel;

  rr_arb2 u_rr_arb2 (
    .req0_i     (bus.req0),
    .req1_i     (bus.req1),
    .last_gnt_i (last_gnt_q),
    .win_o      (w_win),
    .sel_o      (w_sel)
  );

  // Next state: requests only sampled in IDLE, then READ -> [WAIT] -> DONE
  always_comb begin
    state_d    = state_q;
    owner_d    = owner_q;
    last_gnt_d = last_gnt_q;
    cnt_d      = cnt_q;
    addr_d     = addr_q;
    coef2_d    = coef2_q;
    coef1_d    = coef1_q;
    coef0_d    = coef0_q;
    w_capture  = 1'b0;

    case (state_q)
      ST_IDLE: begin
        if (w_win) begin
          addr_d     = (w_sel == REQ_TRIG) ? bus.addr1 : bus.addr0;
          owner_d    = w_sel;
          last_gnt_d = w_sel;
          state_d    = ST_READ;
        end
      end
      ST_READ: begin
        if (c_comb_rom) begin
          w_capture = 1'b1;
          state_d   = ST_DONE;
        end else begin
          cnt_d   = c_lat_m1;
          state_d = ST_WAIT;
        end
      end
      ST_WAIT: begin
        if (cnt_q == 3'd0) begin
          w_capture = 1'b1;
          state_d   = ST_DONE;
        end else begin
          cnt_d = cnt_q - 3'd1;
        end
      end
      ST_DONE: begin
        state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase

    if (w_capture) begin
      coef2_d = bus.rom_coef2;
      coef1_d = bus.rom_coef1;
      coef0_d = bus.rom_coef0;
    end
  end

  // State, counter, latched address and captured coefficients; reset aborts
  // any lookup in flight and discards its result
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= ST_IDLE;
      owner_q    <= REQ_LN;
      last_gnt_q <= REQ_TRIG;
      cnt_q      <= 3'd0;
      busy_q     <= 1'b0;
      addr_q     <= '0;
      coef2_q    <= '0;
      coef1_q    <= '0;
      coef0_q    <= '0;
    end else begin
      state_q    <= state_d;
      owner_q    <= owner_d;
      last_gnt_q <= last_gnt_d;
      cnt_q      <= cnt_d;
      busy_q     <= (state_d != ST_IDLE);
      addr_q     <= addr_d;
      coef2_q    <= coef2_d;
      coef1_q    <= coef1_d;
      coef0_q    <= coef0_d;
    end
  end

  // Strobes decoded from the registered state and owner
  assign bus.rom_read_en = (state_q == ST_READ) || (state_q == ST_WAIT);
  assign bus.rom_address = addr_q;
  assign bus.gnt0        = (state_q == ST_READ) && (owner_q == REQ_LN);
  assign bus.gnt1        = (state_q == ST_READ) && (owner_q == REQ_TRIG);
  assign bus.vld0        = (state_q == ST_DONE) && (owner_q == REQ_LN);
  assign bus.vld1        = (state_q == ST_DONE) && (owner_q == REQ_TRIG);
  assign bus.busy        = busy_q;
  assign bus.coef2_o     = coef2_q;
  assign bus.coef1_o     = coef1_q;
  assign bus.coef0_o     = coef0_q;

endmodule
`default_nettype wire

// File: tb/tb_coef_rom_arbiter.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
//  Module      : tb_coef_rom_arbiter
//  Description : Drives three arbiters (ROM_LAT 0, 2, 3) from one set of
//                requesters, each with a latency-accurate ROM model, and
//                compares them against a lookup-phase reference model.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_coef_rom_arbiter;
  import coef_pkg::*;

  localparam int NI = 3;
  localparam int OW = 6 + ADDR_W + C2_W + C1_W + C0_W;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  logic req0, req1;
  logic [ADDR_W-1:0] addr0, addr1;

  logic              o_gnt0 [NI];
  logic              o_gnt1 [NI];
  logic              o_vld0 [NI];
  logic              o_vld1 [NI];
  logic              o_ren  [NI];
  logic              o_busy [NI];
  logic [ADDR_W-1:0] o_raddr[NI];
  logic [C2_W-1:0]   o_c2   [NI];
  logic [C1_W-1:0]   o_c1   [NI];
  logic [C0_W-1:0]   o_c0   [NI];

  int n_checks = 0;
  int n_pass   = 0;

  always #5 clk = ~clk;

  function automatic int lat_of(input int i);
    return (i == 0) ? 0 : ((i == 1) ? 2 : 3);
  endfunction

  for (genvar gi = 0; gi < NI; gi++) begin : g_dut
    localparam int unsigned L = (gi == 0) ? 0 : ((gi == 1) ? 2 : 3);
    coef_rom_arbiter_if bus ();

    assign bus.req0  = req0;
    assign bus.addr0 = addr0;
    assign bus.req1  = req1;
    assign bus.addr1 = addr1;

    if (L == 0) begin : g_comb
      assign bus.rom_coef2 = {11'b0, bus.rom_address};
      assign bus.rom_coef1 = ~{11'b0, bus.rom_address};
      assign bus.rom_coef0 = {14'b0, bus.rom_address};
    end else begin : g_lat
      // Data is valid L cycles after {read_en, address}; junk otherwise
      bit [ADDR_W:0] pipe [8];
      always @(posedge clk) begin
        pipe[0] <= {bus.rom_read_en, bus.rom_address};
        for (int k = 1; k < 8; k++) pipe[k] <= pipe[k-1];
      end
      wire [ADDR_W:0] tap = pipe[L-1];
      assign bus.rom_coef2 = tap[ADDR_W] ? {11'b0, tap[ADDR_W-1:0]}  : {C2_W{1'b1}};
      assign bus.rom_coef1 = tap[ADDR_W] ? ~{11'b0, tap[ADDR_W-1:0]} : {C1_W{1'b0}};
      assign bus.rom_coef0 = tap[ADDR_W] ? {14'b0, tap[ADDR_W-1:0]}  : {C0_W{1'b1}};
    end

    coef_rom_arbiter #(.ROM_LAT(L)) u_dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus.slave)
    );

    assign o_gnt0[gi]  = bus.gnt0;
    assign o_gnt1[gi]  = bus.gnt1;
    assign o_vld0[gi]  = bus.vld0;
    assign o_vld1[gi]  = bus.vld1;
    assign o_ren[gi]   = bus.rom_read_en;
    assign o_busy[gi]  = bus.busy;
    assign o_raddr[gi] = bus.rom_address;
    assign o_c2[gi]    = bus.coef2_o;
    assign o_c1[gi]    = bus.coef1_o;
    assign o_c0[gi]    = bus.coef0_o;
  end

  // Reference model: m_ph is the cycle index within a lookup (0 = grant
  // cycle, L+1 = result cycle), -1 while the arbiter is free to sample.
  int                m_ph   [NI];
  logic              m_owner[NI];
  logic              m_last [NI];
  logic [ADDR_W-1:0] m_addr [NI];
  logic [ADDR_W-1:0] m_cap  [NI];
  logic              m_capd [NI];

  always @(posedge clk or negedge rst_n) begin
    for (int i = 0; i < NI; i++) begin
      if (!rst_n) begin
        m_ph[i]    <= -1;
        m_owner[i] <= 1'b0;
        m_last[i]  <= 1'b1;
        m_addr[i]  <= '0;
        m_cap[i]   <= '0;
        m_capd[i]  <= 1'b0;
      end else if (m_ph[i] < 0) begin
        if (req0 || req1) begin
          m_owner[i] <= (req0 && req1) ? ~m_last[i] : req1;
          m_last[i]  <= (req0 && req1) ? ~m_last[i] : req1;
          m_addr[i]  <= (((req0 && req1) ? ~m_last[i] : req1) == 1'b1) ? addr1 : addr0;
          m_ph[i]    <= 0;
        end
      end else if (m_ph[i] == lat_of(i) + 1) begin
        m_ph[i] <= -1;
      end else begin
        m_ph[i] <= m_ph[i] + 1;
        if (m_ph[i] == lat_of(i)) begin
          m_capd[i] <= 1'b1;
          m_cap[i]  <= m_addr[i];
        end
      end
    end
  end

  function automatic logic [OW-1:0] exp_vec(input int i);
    int L = lat_of(i);
    logic g0, g1, v0, v1, re, bz;
    logic [ADDR_W-1:0] ca;
    g0 = (m_ph[i] == 0) && !m_owner[i];
    g1 = (m_ph[i] == 0) &&  m_owner[i];
    v0 = (m_ph[i] == L + 1) && !m_owner[i];
    v1 = (m_ph[i] == L + 1) &&  m_owner[i];
    re = (m_ph[i] >= 0) && (m_ph[i] <= L);
    bz = (m_ph[i] >= 0);
    ca = m_cap[i];
    if (m_capd[i])
      return {g0, g1, v0, v1, re, bz, m_addr[i], {11'b0, ca}, ~{11'b0, ca}, {14'b0, ca}};
    return {g0, g1, v0, v1, re, bz, m_addr[i], {C2_W{1'b0}}, {C1_W{1'b0}}, {C0_W{1'b0}}};
  endfunction

  function automatic logic [OW-1:0] obs_vec(input int i);
    return {o_gnt0[i], o_gnt1[i], o_vld0[i], o_vld1[i], o_ren[i], o_busy[i],
            o_raddr[i], o_c2[i], o_c1[i], o_c0[i]};
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst_n = 1'b0; req0 = 1'b0; req1 = 1'b0; addr0 = '0; addr1 = '0;
    repeat (3) tick();
    for (int i = 0; i < NI; i++) begin
      n_checks++;
      if (obs_vec(i) !== '0) $display("FAIL reset_outputs lat=%0d got=%h want=0", lat_of(i), obs_vec(i));
      else n_pass++;
    end
    rst_n = 1'b1;
    tick();
    for (int i = 0; i < NI; i++) begin
      n_checks++;
      if (obs_vec(i) !== '0) $display("FAIL idle_after_reset lat=%0d got=%h want=0", lat_of(i), obs_vec(i));
      else n_pass++;
    end
  endtask

  task automatic test_single_ln();
    int g_at = -1, v_at = -1, ren_n = 0;
    bit v1_seen = 0, bad_addr = 0;
    req0 = 1'b1; addr0 = 7'h05;
    tick();
    req0 = 1'b0;
    for (int c = 1; c <= 8; c++) begin
      for (int i = 0; i < NI; i++) begin
        n_checks++;
        if (obs_vec(i) !== exp_vec(i)) $display("FAIL single_ln lat=%0d c=%0d got=%h want=%h", lat_of(i), c, obs_vec(i), exp_vec(i));
        else n_pass++;
      end
      if (o_gnt0[0]) g_at = c;
      if (o_vld0[0]) v_at = c;
      if (o_vld1[0]) v1_seen = 1;
      if (o_ren[0]) begin
        ren_n++;
        if (o_raddr[0] !== 7'h05) bad_addr = 1;
      end
      tick();
    end
    n_checks++;
    if ({g_at, v_at, ren_n} !== {32'sd1, 32'sd2, 32'sd1})
      $display("FAIL lat0_timing got gnt@%0d vld@%0d ren=%0d want gnt@1 vld@2 ren=1", g_at, v_at, ren_n);
    else n_pass++;
    n_checks++;
    if ({bad_addr, v1_seen} !== 2'b00) $display("FAIL lat0_addr_vld1 got bad_addr=%0d vld1=%0d want 0 0", bad_addr, v1_seen);
    else n_pass++;
    n_checks++;
    if ({o_c2[0], o_c0[0]} !== {18'h00005, 21'h00005}) $display("FAIL lat0_coef got c2=%h c0=%h want 00005 000005", o_c2[0], o_c0[0]);
    else n_pass++;
  endtask

  task automatic test_lat2_trig();
    int g_at = -1, v_at = -1, ren_n = 0;
    bit bad_addr = 0, v0_seen = 0;
    req1 = 1'b1; addr1 = 7'h7F;
    tick();
    req1 = 1'b0;
    for (int c = 1; c <= 8; c++) begin
      for (int i = 0; i < NI; i++) begin
        n_checks++;
        if (obs_vec(i) !== exp_vec(i)) $display("FAIL lat2_trig lat=%0d c=%0d got=%h want=%h", lat_of(i), c, obs_vec(i), exp_vec(i));
        else n_pass++;
      end
      if (o_gnt1[1]) g_at = c;
      if (o_vld1[1]) v_at = c;
      if (o_vld0[1]) v0_seen = 1;
      if (o_ren[1]) begin
        ren_n++;
        if (o_raddr[1] !== 7'h7F) bad_addr = 1;
      end
      tick();
    end
    n_checks++;
    if ({g_at, v_at, ren_n} !== {32'sd1, 32'sd4, 32'sd3})
      $display("FAIL lat2_timing got gnt@%0d vld@%0d ren=%0d want gnt@1 vld@4 ren=3", g_at, v_at, ren_n);
    else n_pass++;
    n_checks++;
    if ({bad_addr, v0_seen} !== 2'b00) $display("FAIL lat2_addr_vld0 got bad_addr=%0d vld0=%0d want 0 0", bad_addr, v0_seen);
    else n_pass++;
    n_checks++;
    if (o_c1[1] !== 18'h3FF80) $display("FAIL lat2_coef1 got=%h want=3ff80", o_c1[1]);
    else n_pass++;
  endtask

  task automatic test_fairness();
    int gord [NI][16];
    int gcnt [NI];
    req0 = 1'b1; req1 = 1'b1; addr0 = 7'd10; addr1 = 7'd20;
    for (int i = 0; i < NI; i++) gcnt[i] = 0;
    for (int c = 0; c < 50; c++) begin
      if (c == 40) begin req0 = 1'b0; req1 = 1'b0; end
      tick();
      for (int i = 0; i < NI; i++) begin
        n_checks++;
        if (obs_vec(i) !== exp_vec(i)) $display("FAIL fairness lat=%0d c=%0d got=%h want=%h", lat_of(i), c, obs_vec(i), exp_vec(i));
        else n_pass++;
        if ((o_gnt0[i] || o_gnt1[i]) && gcnt[i] < 16) begin
          gord[i][gcnt[i]] = o_gnt1[i] ? 1 : 0;
          gcnt[i]++;
        end
        if (o_vld0[i] || o_vld1[i]) begin
          n_checks++;
          if (o_c0[i] !== (o_vld0[i] ? 21'd10 : 21'd20))
            $display("FAIL fair_result lat=%0d vld0=%0d got=%0d", lat_of(i), o_vld0[i], o_c0[i]);
          else n_pass++;
        end
      end
    end
    for (int i = 0; i < NI; i++) begin
      for (int k = 0; k < 6; k++) begin
        n_checks++;
        if (gord[i][k] !== (k % 2)) $display("FAIL fair_order lat=%0d k=%0d got=%0d want=%0d", lat_of(i), k, gord[i][k], k % 2);
        else n_pass++;
      end
    end
  endtask

  task automatic test_withdraw();
    bit seen [NI];
    req1 = 1'b1; addr1 = 7'h33;
    tick();
    req1 = 1'b0; req0 = 1'b1; addr0 = 7'h44;
    tick();
    req0 = 1'b0;
    for (int i = 0; i < NI; i++) seen[i] = 0;
    for (int c = 2; c <= 12; c++) begin
      for (int i = 0; i < NI; i++) begin
        n_checks++;
        if (obs_vec(i) !== exp_vec(i)) $display("FAIL withdraw lat=%0d c=%0d got=%h want=%h", lat_of(i), c, obs_vec(i), exp_vec(i));
        else n_pass++;
        if (o_gnt0[i] || o_vld0[i] || (o_ren[i] && o_raddr[i] == 7'h44)) seen[i] = 1;
      end
      tick();
    end
    for (int i = 0; i < NI; i++) begin
      n_checks++;
      if (seen[i] !== 1'b0) $display("FAIL withdraw_no_lookup lat=%0d got=1 want=0", lat_of(i));
      else n_pass++;
    end
  endtask

  task automatic test_reset_mid();
    int first [NI];
    req0 = 1'b1; addr0 = 7'h2A;
    tick();
    req0 = 1'b0;
    tick();
    rst_n = 1'b0;
    #1;
    for (int i = 0; i < NI; i++) begin
      n_checks++;
      if (obs_vec(i) !== '0) $display("FAIL reset_mid_zero lat=%0d got=%h want=0", lat_of(i), obs_vec(i));
      else n_pass++;
    end
    req0 = 1'b1; req1 = 1'b1; addr0 = 7'h11; addr1 = 7'h22;
    tick();
    for (int i = 0; i < NI; i++) begin
      n_checks++;
      if (obs_vec(i) !== '0) $display("FAIL reset_hold_zero lat=%0d got=%h want=0", lat_of(i), obs_vec(i));
      else n_pass++;
      first[i] = -1;
    end
    rst_n = 1'b1;
    for (int c = 1; c <= 12; c++) begin
      if (c == 9) begin req0 = 1'b0; req1 = 1'b0; end
      tick();
      for (int i = 0; i < NI; i++) begin
        n_checks++;
        if (obs_vec(i) !== exp_vec(i)) $display("FAIL reset_mid lat=%0d c=%0d got=%h want=%h", lat_of(i), c, obs_vec(i), exp_vec(i));
        else n_pass++;
        if (first[i] < 0 && (o_gnt0[i] || o_gnt1[i])) first[i] = o_gnt1[i] ? 1 : 0;
      end
    end
    for (int i = 0; i < NI; i++) begin
      n_checks++;
      if (first[i] !== 0) $display("FAIL reset_first_grant lat=%0d got=%0d want=0", lat_of(i), first[i]);
      else n_pass++;
    end
    repeat (4) tick();
  endtask

  task automatic test_back_to_back();
    int low_run [NI];
    int gaps    [NI];
    int bad     [NI];
    bit started [NI];
    req0 = 1'b1; req1 = 1'b0; addr0 = 7'h5A;
    for (int i = 0; i < NI; i++) begin low_run[i] = 0; gaps[i] = 0; bad[i] = 0; started[i] = 0; end
    for (int c = 0; c < 30; c++) begin
      tick();
      for (int i = 0; i < NI; i++) begin
        n_checks++;
        if (obs_vec(i) !== exp_vec(i)) $display("FAIL back_to_back lat=%0d c=%0d got=%h want=%h", lat_of(i), c, obs_vec(i), exp_vec(i));
        else n_pass++;
        if (o_gnt0[i]) started[i] = 1;
        if (o_busy[i]) begin
          if (low_run[i] > 0) begin
            gaps[i]++;
            if (low_run[i] != 1) bad[i]++;
          end
          low_run[i] = 0;
        end else if (started[i]) begin
          low_run[i]++;
        end
      end
    end
    req0 = 1'b0;
    for (int i = 0; i < NI; i++) begin
      n_checks++;
      if (gaps[i] < 3 || bad[i] != 0) $display("FAIL b2b_busy_gap lat=%0d got gaps=%0d bad=%0d want >=3 gaps of 1", lat_of(i), gaps[i], bad[i]);
      else n_pass++;
    end
    repeat (8) tick();
  endtask

  task automatic test_random();
    for (int c = 0; c < 400; c++) begin
      rst_n = ($urandom_range(0, 63) == 0) ? 1'b0 : 1'b1;
      req0  = ($urandom_range(0, 2) != 0);
      req1  = ($urandom_range(0, 2) != 0);
      addr0 = ($urandom_range(0, 3) == 0) ? (($urandom_range(0, 1) == 0) ? 7'h00 : 7'h7F) : 7'($urandom);
      addr1 = ($urandom_range(0, 3) == 0) ? (($urandom_range(0, 1) == 0) ? 7'h00 : 7'h7F) : 7'($urandom);
      tick();
      for (int i = 0; i < NI; i++) begin
        n_checks++;
        if (obs_vec(i) !== exp_vec(i)) $display("FAIL random lat=%0d c=%0d got=%h want=%h", lat_of(i), c, obs_vec(i), exp_vec(i));
        else n_pass++;
      end
    end
    rst_n = 1'b1; req0 = 1'b0; req1 = 1'b0;
    repeat (8) tick();
  endtask

  initial begin
    test_reset();
    test_single_ln();
    test_lat2_trig();
    test_fairness();
    test_withdraw();
    test_reset_mid();
    test_back_to_back();
    test_random();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
`default_nettype wire
